// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 8-bit CPU: opcode/func encodings, sequencer
// cycle numbers, instruction classes and ALU control codes.
package cpu_isa_pkg;

    localparam int OPC_W   = 4;
    localparam int FUNC_W  = 4;
    localparam int STATE_W = 3;

    typedef logic [OPC_W-1:0]   opcode_t;
    typedef logic [FUNC_W-1:0]  func_t;
    typedef logic [STATE_W-1:0] seq_state_t;

    // Primary opcodes; 0111 is reserved and decodes as illegal.
    localparam opcode_t OP_RTYPE = 4'b0000;
    localparam opcode_t OP_ADDI  = 4'b0001;
    localparam opcode_t OP_SUBI  = 4'b0010;
    localparam opcode_t OP_ANDI  = 4'b0011;
    localparam opcode_t OP_ORI   = 4'b0100;
    localparam opcode_t OP_XORI  = 4'b0101;
    localparam opcode_t OP_CMPI  = 4'b0110;
    localparam opcode_t OP_ILL   = 4'b0111;
    localparam opcode_t OP_RET   = 4'b1000;
    localparam opcode_t OP_RCALL = 4'b1001;
    localparam opcode_t OP_RJMP  = 4'b1010;
    localparam opcode_t OP_JE    = 4'b1011;
    localparam opcode_t OP_JNE   = 4'b1100;
    localparam opcode_t OP_JB    = 4'b1101;
    localparam opcode_t OP_JAE   = 4'b1110;
    localparam opcode_t OP_JL    = 4'b1111;

    // R-type function codes; 0000, 0110 and 0111 are illegal.
    localparam func_t FN_ADD   = 4'b0001;
    localparam func_t FN_SUB   = 4'b0010;
    localparam func_t FN_AND   = 4'b0011;
    localparam func_t FN_OR    = 4'b0100;
    localparam func_t FN_XOR   = 4'b0101;
    localparam func_t FN_LSR   = 4'b1000;
    localparam func_t FN_LSL   = 4'b1001;
    localparam func_t FN_ASR   = 4'b1010;
    localparam func_t FN_PUSH  = 4'b1011;
    localparam func_t FN_POP   = 4'b1100;
    localparam func_t FN_PUSHF = 4'b1101;
    localparam func_t FN_POPF  = 4'b1110;
    localparam func_t FN_CMP   = 4'b1111;

    localparam seq_state_t S_FETCH  = 3'd0;
    localparam seq_state_t S_DECODE = 3'd1;
    localparam seq_state_t S_EXEC   = 3'd2;
    localparam seq_state_t S_WB     = 3'd3;
    localparam seq_state_t S_PC     = 3'd4;
    localparam seq_state_t S_CALL   = 3'd5;
    localparam seq_state_t S_LAST   = S_CALL;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_LSR  = 4'd5,
        ALU_LSL  = 4'd6,
        ALU_ASR  = 4'd7,
        ALU_PASS = 4'd8
    } alu_ctrl_e;

    typedef enum logic [3:0] {
        CLS_NOP   = 4'd0,
        CLS_ALU   = 4'd1,
        CLS_CMP   = 4'd2,
        CLS_JMP   = 4'd3,
        CLS_BR    = 4'd4,
        CLS_PUSH  = 4'd5,
        CLS_POP   = 4'd6,
        CLS_POPF  = 4'd7,
        CLS_RET   = 4'd8,
        CLS_RCALL = 4'd9
    } instr_class_e;

    typedef struct packed {
        instr_class_e cls;
        seq_state_t   last_state;
        logic         illegal;
    } class_info_t;

    // Cycle in which each class raises instr_done.
    function automatic seq_state_t class_last_state(input instr_class_e cls);
        case (cls)
            CLS_CMP, CLS_JMP, CLS_BR:             return S_EXEC;
            CLS_ALU, CLS_PUSH, CLS_POP, CLS_POPF: return S_WB;
            CLS_RET:                              return S_PC;
            CLS_RCALL:                            return S_CALL;
            default:                              return S_DECODE;
        endcase
    endfunction

    // ALU operation for the execute cycle; ADD is the default so that the
    // fetch-cycle PC increment needs no special case in the ALU decoder.
    function automatic alu_ctrl_e alu_ctrl_for(input opcode_t op, input func_t fn);
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SUB, FN_CMP: return ALU_SUB;
                    FN_AND:         return ALU_AND;
                    FN_OR:          return ALU_OR;
                    FN_XOR:         return ALU_XOR;
                    FN_LSR:         return ALU_LSR;
                    FN_LSL:         return ALU_LSL;
                    FN_ASR:         return ALU_ASR;
                    FN_PUSH, FN_PUSHF, FN_POP, FN_POPF: return ALU_PASS;
                    default:        return ALU_ADD;
                endcase
            end
            OP_SUBI, OP_CMPI: return ALU_SUB;
            OP_ANDI:          return ALU_AND;
            OP_ORI:           return ALU_OR;
            OP_XORI:          return ALU_XOR;
            default:          return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/instr_class_dec.sv
// Combinational instruction classifier: opcode/func -> {class, last cycle,
// illegal}. Shared by the sequencer to pick its per-cycle schedule.
module instr_class_dec
    import cpu_isa_pkg::*;
(
    input  opcode_t     opcode_i,
    input  func_t       func_i,
    output class_info_t info_o
);

    instr_class_e cls;
    logic         illegal;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the case statements can leave it holding a value.
        cls     = CLS_NOP;
        illegal = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (func_i)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
                    FN_LSR, FN_LSL, FN_ASR: cls = CLS_ALU;
                    FN_CMP:                 cls = CLS_CMP;
                    FN_PUSH, FN_PUSHF:      cls = CLS_PUSH;
                    FN_POP:                 cls = CLS_POP;
                    FN_POPF:                cls = CLS_POPF;
                    default:                illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: cls = CLS_ALU;
            OP_CMPI:                                    cls = CLS_CMP;
            OP_RET:                                     cls = CLS_RET;
            OP_RCALL:                                   cls = CLS_RCALL;
            OP_RJMP:                                    cls = CLS_JMP;
            OP_JE, OP_JNE, OP_JB, OP_JAE, OP_JL:        cls = CLS_BR;
            default:                                    illegal = 1'b1;
        endcase

        info_o.cls        = cls;
        info_o.last_state = class_last_state(cls);
        info_o.illegal    = illegal;
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: fetches into IR, steps a 3-bit cycle counter
// and emits write strobes and data-memory handshakes. Optional single-step
// control is enabled with the INSTR_SEQ_STEP_EN macro.
module instr_sequencer
    import cpu_isa_pkg::*;
#(
    parameter int INSTR_WIDTH  = 16,
    parameter int OPCODE_WIDTH = OPC_W,
    parameter int FUNC_WIDTH   = FUNC_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [INSTR_WIDTH-1:0]  instr_in,
    input  logic                    instr_valid,
    output logic                    instr_req,
    input  logic                    mem_ack,
    output logic                    mem_req,
    output logic                    mem_we,
    input  logic                    cond_true,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [FUNC_WIDTH-1:0]   func,
    output logic [2:0]              state,
    output logic                    pc_we,
    output logic                    reg_we,
    output logic                    flags_we,
    output logic                    sp_we,
`ifdef INSTR_SEQ_STEP_EN
    input  logic                    step,
    output logic                    halted,
`endif
    output logic                    instr_done
);

    seq_state_t             state_q, state_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   quiet_q;
    logic                   fetch_en;
    logic                   advance;
    class_info_t            info;

    assign opcode = ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign func   = ir_q[FUNC_WIDTH-1:0];
    assign state  = state_q;

    // Operand bits are consumed by the datapath, not by the sequencer.
    logic operand_bits_unused;
    assign operand_bits_unused = ^ir_q[INSTR_WIDTH-OPCODE_WIDTH-1:FUNC_WIDTH];

    instr_class_dec u_class_dec (
        .opcode_i (opcode),
        .func_i   (func),
        .info_o   (info)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (reset) begin
            // NOTE: IR is a real register, not storage, so it gets a reset value
            // and opcode/func decode as a clean RTYPE/0 after reset.
            state_q <= S_FETCH;
            ir_q    <= '0;
            quiet_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            quiet_q <= 1'b0;
        end
    end

`ifdef INSTR_SEQ_STEP_EN
    logic halted_q, halted_d;

    always_comb begin
        halted_d = halted_q;
        if (instr_done) begin
            halted_d = 1'b1;
        end else if (!quiet_q && state_q == S_FETCH && halted_q && step) begin
            halted_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) halted_q <= 1'b1;
        else       halted_q <= halted_d;
    end

    assign fetch_en = ~halted_q;
    assign halted   = halted_q;
`else
    assign fetch_en = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        instr_req  = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        flags_we   = 1'b0;
        sp_we      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        instr_done = 1'b0;
        advance    = 1'b0;

        // The cycle right after reset is kept silent so no strobe or request
        // can escape before the rest of the CPU has left reset.
        if (!quiet_q) begin
            if (state_q > S_LAST) begin
                state_d = S_FETCH;
            end else if (state_q == S_FETCH) begin
                if (fetch_en) begin
                    instr_req = 1'b1;
                    if (instr_valid) begin
                        ir_d    = instr_in;
                        pc_we   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
            end else begin
                advance = 1'b1;
                case (info.cls)
                    CLS_ALU: begin
                        flags_we = (state_q == S_EXEC);
                        reg_we   = (state_q == S_WB);
                    end
                    CLS_CMP: flags_we = (state_q == S_EXEC);
                    CLS_JMP: pc_we    = (state_q == S_EXEC);
                    CLS_BR:  pc_we    = (state_q == S_EXEC) && cond_true;
                    CLS_PUSH: begin
                        if (state_q == S_EXEC) begin
                            mem_req = 1'b1;
                            mem_we  = 1'b1;
                            advance = mem_ack;
                        end
                        sp_we = (state_q == S_WB);
                    end
                    CLS_POP, CLS_POPF: begin
                        if (state_q == S_EXEC) begin
                            mem_req = 1'b1;
                            advance = mem_ack;
                        end
                        sp_we    = (state_q == S_WB);
                        reg_we   = (state_q == S_WB) && (info.cls == CLS_POP);
                        flags_we = (state_q == S_WB) && (info.cls == CLS_POPF);
                    end
                    CLS_RET: begin
                        if (state_q == S_EXEC) begin
                            mem_req = 1'b1;
                            advance = mem_ack;
                        end
                        sp_we = (state_q == S_WB);
                        pc_we = (state_q == S_PC);
                    end
                    CLS_RCALL: begin
                        sp_we = (state_q == S_WB);
                        pc_we = (state_q == S_PC);
                        if (state_q == S_CALL) begin
                            mem_req = 1'b1;
                            mem_we  = 1'b1;
                            advance = mem_ack;
                        end
                    end
                    default: ;
                endcase

                // A memory cycle gates its done pulse along with everything else.
                if (advance) begin
                    if (info.illegal || state_q >= info.last_state) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = state_q + 3'd1;
                    end
                end
            end
        end
    end

endmodule
